// File: rtl/routing_mux_pipelined.sv
// Purpose: N:1 routing mux for kFPGA switch boxes, selector loaded over a serial config chain.
// Latency: popcount(PIPE_MASK) cycles from data_in/data_valid_in to data_out/data_valid_out; 0 = combinational.
// Backpressure: none; the datapath advances every cycle and data_valid_out only qualifies data_out.
// Optional feature macro: KFPGA_MUX_SHADOW_EN (shadow config register plus config_latch input).
module routing_mux_pipelined #(
    parameter int                   INPUTS    = 34,
    parameter int                   SEL_WIDTH = 6,
    parameter logic [SEL_WIDTH-1:0] PIPE_MASK = 6'b000001
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INPUTS-1:0] data_in,
    input  logic              data_valid_in,
    output logic              data_out,
    output logic              data_valid_out,
    input  logic              config_enable,
    input  logic              config_in,
`ifdef KFPGA_MUX_SHADOW_EN
    input  logic              config_latch,
`endif
    output logic              config_out
);

    localparam int NP = 1 << SEL_WIDTH;

    // Active selector; this is the only selector the datapath sees.
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
`ifdef KFPGA_MUX_SHADOW_EN
    // Chain-facing shadow copy, copied to the active selector on config_latch.
    logic [SEL_WIDTH-1:0] shadow_q, shadow_d;
`endif

    // Inputs zero-padded to a power of two so every halving stage is uniform.
    logic [NP-1:0] pad_dat;

    // Per-level view of the datapath: index SEL_WIDTH is the mux input,
    // index k is the value after stage k (registered or not).
    logic [NP-1:0]        lvl_dat [0:SEL_WIDTH];
    logic [SEL_WIDTH-1:0] lvl_sel [0:SEL_WIDTH];
    logic                 lvl_vld [0:SEL_WIDTH];

    // Optional pipeline registers after each stage; only those with PIPE_MASK[k] set are read.
    logic [NP-1:0]        stg_dat_q [0:SEL_WIDTH-1];
    logic [NP-1:0]        stg_dat_d [0:SEL_WIDTH-1];
    logic [SEL_WIDTH-1:0] stg_sel_q [0:SEL_WIDTH-1];
    logic [SEL_WIDTH-1:0] stg_sel_d [0:SEL_WIDTH-1];
    logic                 stg_vld_q [0:SEL_WIDTH-1];
    logic                 stg_vld_d [0:SEL_WIDTH-1];

    // Next-state of the config chain: shift LSB-first toward config_out.
    always_comb begin
        sel_d = sel_q;
`ifdef KFPGA_MUX_SHADOW_EN
        shadow_d = shadow_q;
        if (config_enable) begin
            shadow_d = {config_in, shadow_q[SEL_WIDTH-1:1]};
        end
        // The active register takes the pre-shift shadow when both are asserted.
        if (config_latch) begin
            sel_d = shadow_q;
        end
`else
        if (config_enable) begin
            sel_d = {config_in, sel_q[SEL_WIDTH-1:1]};
        end
`endif
    end

    // Pad the routed inputs with zeros so out-of-range selectors yield 0.
    always_comb begin
        pad_dat = '0;
        pad_dat[INPUTS-1:0] = data_in;
    end

    // Halving stages from the MSB selector bit down; each sample carries its own selector bits.
    always_comb begin
        lvl_dat[SEL_WIDTH] = pad_dat;
        lvl_sel[SEL_WIDTH] = sel_q;
        lvl_vld[SEL_WIDTH] = data_valid_in;
        for (int k = SEL_WIDTH - 1; k >= 0; k--) begin
            // Upper half is moved down into the low bits; bits above 2^k are don't-care.
            stg_dat_d[k] = lvl_sel[k+1][k] ? (lvl_dat[k+1] >> (1 << k)) : lvl_dat[k+1];
            stg_sel_d[k] = lvl_sel[k+1];
            stg_vld_d[k] = lvl_vld[k+1];
            if (PIPE_MASK[k]) begin
                lvl_dat[k] = stg_dat_q[k];
                lvl_sel[k] = stg_sel_q[k];
                lvl_vld[k] = stg_vld_q[k];
            end else begin
                lvl_dat[k] = stg_dat_d[k];
                lvl_sel[k] = stg_sel_d[k];
                lvl_vld[k] = stg_vld_d[k];
            end
        end
    end

    // State update: reset clears configuration and every in-flight sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q <= '0;
`ifdef KFPGA_MUX_SHADOW_EN
            shadow_q <= '0;
`endif
            for (int k = 0; k < SEL_WIDTH; k++) begin
                stg_dat_q[k] <= '0;
                stg_sel_q[k] <= '0;
                stg_vld_q[k] <= 1'b0;
            end
        end else begin
            sel_q <= sel_d;
`ifdef KFPGA_MUX_SHADOW_EN
            shadow_q <= shadow_d;
`endif
            for (int k = 0; k < SEL_WIDTH; k++) begin
                stg_dat_q[k] <= stg_dat_d[k];
                stg_sel_q[k] <= stg_sel_d[k];
                stg_vld_q[k] <= stg_vld_d[k];
            end
        end
    end

    // Outputs: the last level's bit 0 is the routed signal; the chain tail is a flop output.
    always_comb begin
        data_out       = lvl_dat[0][0];
        data_valid_out = lvl_vld[0];
`ifdef KFPGA_MUX_SHADOW_EN
        config_out     = shadow_q[0];
`else
        config_out     = sel_q[0];
`endif
    end

endmodule

// File: tb/tb_routing_mux_pipelined.sv
// Randomised scoreboard bench for routing_mux_pipelined: three instances (LAT 1, 3, 6)
// share stimulus; a reference model predicts each valid sample's routed bit and exit cycle.
// Build with KFPGA_MUX_SHADOW_EN defined to also exercise the shadow config register.
module tb_routing_mux_pipelined;

    localparam int N  = 34;
    localparam int SW = 6;
    localparam int ND = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  data_in = '0;
    logic          data_valid_in = 1'b0;
    logic          config_enable = 1'b0;
    logic          config_in = 1'b0;
`ifdef KFPGA_MUX_SHADOW_EN
    logic          config_latch = 1'b0;
`endif
    logic [ND-1:0] dout;
    logic [ND-1:0] dvo;
    logic [ND-1:0] cfo;

    typedef struct {
        logic val;
        int   cyc;
    } exp_t;

    exp_t expq [ND][$];
    int   cyc    = 0;
    int   sel_m  = 0;
    int   sh_m   = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    always #5 clock = ~clock;

    routing_mux_pipelined #(.INPUTS(N), .SEL_WIDTH(SW), .PIPE_MASK(6'b000001)) u_l1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .data_out(dout[0]), .data_valid_out(dvo[0]), .config_enable(config_enable),
        .config_in(config_in),
`ifdef KFPGA_MUX_SHADOW_EN
        .config_latch(config_latch),
`endif
        .config_out(cfo[0]));

    routing_mux_pipelined #(.INPUTS(N), .SEL_WIDTH(SW), .PIPE_MASK(6'b100101)) u_l3 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .data_out(dout[1]), .data_valid_out(dvo[1]), .config_enable(config_enable),
        .config_in(config_in),
`ifdef KFPGA_MUX_SHADOW_EN
        .config_latch(config_latch),
`endif
        .config_out(cfo[1]));

    routing_mux_pipelined #(.INPUTS(N), .SEL_WIDTH(SW), .PIPE_MASK(6'b111111)) u_l6 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .data_out(dout[2]), .data_valid_out(dvo[2]), .config_enable(config_enable),
        .config_in(config_in),
`ifdef KFPGA_MUX_SHADOW_EN
        .config_latch(config_latch),
`endif
        .config_out(cfo[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 6;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the selector as an integer, a sample's output is the
    // selected input bit (zero when out of range) as the selector stood at entry.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            sel_m = 0;
            sh_m  = 0;
            for (int d = 0; d < ND; d++) expq[d].delete();
        end else begin
            if (data_valid_in) begin
                exp_t e;
                e.val = (sel_m < N) ? data_in[sel_m] : 1'b0;
                e.cyc = cyc;
                for (int d = 0; d < ND; d++) expq[d].push_back(e);
            end
`ifdef KFPGA_MUX_SHADOW_EN
            if (config_latch) sel_m = sh_m;
            if (config_enable) sh_m = (sh_m >> 1) | (int'(config_in) << (SW - 1));
`else
            if (config_enable) sel_m = (sel_m >> 1) | (int'(config_in) << (SW - 1));
`endif
        end
    end

    // Monitor: checks config_out every cycle and pops one expectation per valid output.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
`ifdef KFPGA_MUX_SHADOW_EN
                chk($sformatf("config_out[lat%0d]", lat_of(d)), int'(cfo[d]), sh_m & 1);
`else
                chk($sformatf("config_out[lat%0d]", lat_of(d)), int'(cfo[d]), sel_m & 1);
`endif
                if (dvo[d]) begin
                    if (expq[d].size() == 0) begin
                        chk($sformatf("unexpected_valid[lat%0d]", lat_of(d)), int'(dvo[d]), 0);
                    end else begin
                        exp_t e;
                        e = expq[d].pop_front();
                        chk($sformatf("data_out[lat%0d]", lat_of(d)), int'(dout[d]), int'(e.val));
                        chk($sformatf("exit_cycle[lat%0d]", lat_of(d)), cyc, e.cyc + lat_of(d) - 1);
                    end
                end
            end
        end
    end

    function automatic logic [N-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[N-1:0];
    endfunction

    task automatic step(input logic [N-1:0] d, input logic v, input logic ce,
                        input logic ci, input logic rst);
        data_in       = d;
        data_valid_in = v;
        config_enable = ce;
        config_in     = ci;
        reset         = rst;
        @(posedge clock);
        #1;
    endtask

    // Shift a selector value in LSB-first, optionally streaming valid random samples.
    task automatic shift_sel(input int value, input bit stream);
        for (int i = 0; i < SW; i++) begin
            step(stream ? rand_data() : '0, stream, 1'b1, 1'(value >> i), 1'b0);
        end
        config_enable = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clock);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_data_out[lat%0d]", tag, lat_of(d)), int'(dout[d]), 0);
            chk($sformatf("%s_valid_out[lat%0d]", tag, lat_of(d)), int'(dvo[d]), 0);
            chk($sformatf("%s_config_out[lat%0d]", tag, lat_of(d)), int'(cfo[d]), 0);
        end
    endtask

`ifdef KFPGA_MUX_SHADOW_EN
    task automatic latch_pulse(input bit stream);
        config_latch = 1'b1;
        step(stream ? rand_data() : '0, stream, 1'b0, 1'b0, 1'b0);
        config_latch = 1'b0;
    endtask
`endif

    initial begin
        // Reset and initial output state.
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step('0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_reset_outputs("reset");

`ifdef KFPGA_MUX_SHADOW_EN
        latch_pulse(1'b0);
`endif
        // Selector 13 (bits 1,0,1,1,0,0 LSB-first): bit 13 set, then cleared.
        shift_sel(13, 1'b0);
`ifdef KFPGA_MUX_SHADOW_EN
        latch_pulse(1'b0);
`endif
        step(34'h0_0000_2000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(34'h3_ffff_dfff, 1'b1, 1'b0, 1'b0, 1'b0);
        step(34'h0_0000_2000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Top input and an out-of-range selector.
        shift_sel(33, 1'b0);
`ifdef KFPGA_MUX_SHADOW_EN
        latch_pulse(1'b0);
`endif
        step(34'h2_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(34'h1_ffff_ffff, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_sel(40, 1'b0);
`ifdef KFPGA_MUX_SHADOW_EN
        latch_pulse(1'b0);
`endif
        step('1, 1'b1, 1'b0, 1'b0, 1'b0);
        step('1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Single-cycle valid pulse, then reconfiguration 5 -> 20 with samples in flight.
        shift_sel(5, 1'b0);
`ifdef KFPGA_MUX_SHADOW_EN
        latch_pulse(1'b0);
`endif
        step(34'h0_0000_0020, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(rand_data(), 1'b1, 1'b0, 1'b0, 1'b0);
        shift_sel(20, 1'b1);
`ifdef KFPGA_MUX_SHADOW_EN
        latch_pulse(1'b1);
`endif
        for (int i = 0; i < 8; i++) step(rand_data(), 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with random config activity.
        for (int i = 0; i < 400; i++) begin
`ifdef KFPGA_MUX_SHADOW_EN
            config_latch = ($urandom_range(0, 7) == 0);
`endif
            step(rand_data(), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);
        end
`ifdef KFPGA_MUX_SHADOW_EN
        config_latch = 1'b0;
`endif

        // Reset mid-stream with valid samples in flight, then read back zeros on the chain.
        for (int i = 0; i < 4; i++) step(rand_data(), 1'b1, 1'b1, 1'b1, 1'b0);
        step(rand_data(), 1'b1, 1'b1, 1'b1, 1'b1);
        check_reset_outputs("midreset");
        shift_sel(0, 1'b0);

`ifdef KFPGA_MUX_SHADOW_EN
        // Route from 2, load 7 into the shadow while streaming, then latch.
        shift_sel(2, 1'b0);
        latch_pulse(1'b0);
        shift_sel(7, 1'b1);
        for (int i = 0; i < 3; i++) step(rand_data(), 1'b1, 1'b0, 1'b0, 1'b0);
        latch_pulse(1'b1);
        for (int i = 0; i < 6; i++) step(rand_data(), 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Drain and confirm every expected sample came out.
        for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("queue_drained[lat%0d]", lat_of(d)), expq[d].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
